vpu_issue_ctrl: RTL and testbench

Issue controller that sits directly upstream of the VPU latency counter. It accepts vector-op requests through a valid/ready handshake and buffers them in a small FIFO. For each op it looks up a programmable per-opcode latency, fires a one-cycle start with that latency to the downstream counter, waits for the counter's done, and then returns a tagged completion response. Ops are serialized: one op is in flight at a time.

---
 rtl/vpu_issue_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_vpu_issue_ctrl.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vpu_issue_ctrl
// Brief    : Serialising issue controller in front of the VPU latency counter.
//            Requests are buffered in a FIFO. Each op is issued with its
//            programmed latency, waits for done, and then returns a tagged
//            response. Defining VPU_ISSUE_PERF_EN adds the perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module vpu_issue_ctrl #(
    parameter int OPCODE_WIDTH   = 4,
    parameter int TAG_WIDTH      = 4,
    parameter int MAX_DELAY_LG2  = 4,
    parameter int FIFO_DEPTH_LG2 = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [OPCODE_WIDTH-1:0]  req_opcode_i,
    input  logic [TAG_WIDTH-1:0]     req_tag_i,

    input  logic                     cfg_we_i,
    input  logic [OPCODE_WIDTH-1:0]  cfg_opcode_i,
    input  logic [MAX_DELAY_LG2-1:0] cfg_delay_i,

    output logic                     cntr_start_o,
    output logic [MAX_DELAY_LG2-1:0] cntr_count_o,
    input  logic                     cntr_done_i,

    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [TAG_WIDTH-1:0]     rsp_tag_o,
    output logic [OPCODE_WIDTH-1:0]  rsp_opcode_o,

    output logic                     busy_o
`ifdef VPU_ISSUE_PERF_EN
    ,
    output logic [31:0]              perf_busy_cycles_o,
    output logic [15:0]              perf_ops_o
`endif
);

    localparam int NUM_OPS    = 1 << OPCODE_WIDTH;
    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LG2;
    localparam int ENTRY_W    = OPCODE_WIDTH + TAG_WIDTH;

    localparam logic [FIFO_DEPTH_LG2-1:0] PTR_ONE   = FIFO_DEPTH_LG2'(1);
    localparam logic [FIFO_DEPTH_LG2:0]   CNT_ONE   = (FIFO_DEPTH_LG2 + 1)'(1);
    localparam logic [FIFO_DEPTH_LG2:0]   CNT_FULL  = (FIFO_DEPTH_LG2 + 1)'(FIFO_DEPTH);
    localparam logic [MAX_DELAY_LG2-1:0]  DELAY_ONE = MAX_DELAY_LG2'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                    state_q, state_d;

    logic [ENTRY_W-1:0]        fifo_mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH_LG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_DEPTH_LG2:0]   count_q, count_d;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic [ENTRY_W-1:0]        head;
    logic [OPCODE_WIDTH-1:0]   head_opcode;

    logic [MAX_DELAY_LG2-1:0]  table_q [NUM_OPS];

    logic [ENTRY_W-1:0]        inflight_q;
    logic [TAG_WIDTH-1:0]      rsp_tag_q;
    logic [OPCODE_WIDTH-1:0]   rsp_opcode_q;

    // ------------------------------------------------------------------
    // Request FIFO; ready is taken from the registered count only
    // ------------------------------------------------------------------
    assign fifo_full   = (count_q == CNT_FULL);
    assign fifo_empty  = (count_q == '0);
    assign req_ready_o = !fifo_full;
    assign push        = req_valid_i && req_ready_o;
    assign head        = fifo_mem_q[rd_ptr_q];
    assign head_opcode = head[ENTRY_W-1:TAG_WIDTH];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {req_opcode_i, req_tag_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Latency table; a zero latency would never complete, so it maps to 1
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                table_q[i] <= DELAY_ONE;
            end
        end else if (cfg_we_i) begin
            table_q[cfg_opcode_i] <= (cfg_delay_i == '0) ? DELAY_ONE : cfg_delay_i;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        cntr_start_o = 1'b0;
        cntr_count_o = '0;
        rsp_valid_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // The counter ignores start while done is still high
                if (!fifo_empty && !cntr_done_i) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pop          = 1'b1;
                cntr_start_o = 1'b1;
                cntr_count_o = table_q[head_opcode];
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                if (cntr_done_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response fields are only refreshed on entry to RESP so they hold in between
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q   <= '0;
            rsp_tag_q    <= '0;
            rsp_opcode_q <= '0;
        end else begin
            if (pop) begin
                inflight_q <= head;
            end
            if ((state_q == ST_WAIT) && cntr_done_i) begin
                rsp_tag_q    <= inflight_q[TAG_WIDTH-1:0];
                rsp_opcode_q <= inflight_q[ENTRY_W-1:TAG_WIDTH];
            end
        end
    end

    assign rsp_tag_o    = rsp_tag_q;
    assign rsp_opcode_o = rsp_opcode_q;
    assign busy_o       = (state_q != ST_IDLE) || !fifo_empty;

`ifdef VPU_ISSUE_PERF_EN
    logic [31:0] perf_busy_q;
    logic [15:0] perf_ops_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_q <= '0;
            perf_ops_q  <= '0;
        end else begin
            if ((state_q != ST_IDLE) && (perf_busy_q != 32'hFFFF_FFFF)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (rsp_valid_o && rsp_ready_i) begin
                perf_ops_q <= perf_ops_q + 16'd1;
            end
        end
    end

    assign perf_busy_cycles_o = perf_busy_q;
    assign perf_ops_o         = perf_ops_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vpu_issue_ctrl
// Brief    : Self-checking bench for vpu_issue_ctrl: directed scenarios plus a
//            randomized run against a queue/array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vpu_issue_ctrl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [3:0] req_opcode_i;
    logic [3:0] req_tag_i;
    logic       cfg_we_i;
    logic [3:0] cfg_opcode_i;
    logic [3:0] cfg_delay_i;
    logic       cntr_start_o;
    logic [3:0] cntr_count_o;
    logic       cntr_done_i;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [3:0] rsp_tag_o;
    logic [3:0] rsp_opcode_o;
    logic       busy_o;
`ifdef VPU_ISSUE_PERF_EN
    logic [31:0] perf_busy_cycles_o;
    logic [15:0] perf_ops_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit auto_done = 1'b0;
    int lat_left  = 0;

    vpu_issue_ctrl #(
        .OPCODE_WIDTH   (4),
        .TAG_WIDTH      (4),
        .MAX_DELAY_LG2  (4),
        .FIFO_DEPTH_LG2 (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_opcode_i (req_opcode_i),
        .req_tag_i    (req_tag_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_opcode_i (cfg_opcode_i),
        .cfg_delay_i  (cfg_delay_i),
        .cntr_start_o (cntr_start_o),
        .cntr_count_o (cntr_count_o),
        .cntr_done_i  (cntr_done_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_tag_o    (rsp_tag_o),
        .rsp_opcode_o (rsp_opcode_o),
        .busy_o       (busy_o)
`ifdef VPU_ISSUE_PERF_EN
        ,
        .perf_busy_cycles_o (perf_busy_cycles_o),
        .perf_ops_o         (perf_ops_o)
`endif
    );

    always #5 clk = ~clk;

    // One clock; outputs are sampled 1 time unit after the edge. When enabled,
    // a model of the downstream counter pulses done 'latency' cycles after start.
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_done) begin
            cntr_done_i = 1'b0;
            if (cntr_start_o) begin
                lat_left = int'(cntr_count_o);
            end else if (lat_left > 0) begin
                lat_left--;
                if (lat_left == 0) cntr_done_i = 1'b1;
            end
        end
    endtask

    task automatic idle_inputs();
        req_valid_i  = 1'b0;
        req_opcode_i = '0;
        req_tag_i    = '0;
        cfg_we_i     = 1'b0;
        cfg_opcode_i = '0;
        cfg_delay_i  = '0;
        cntr_done_i  = 1'b0;
        rsp_ready_i  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        auto_done = 1'b0;
        lat_left  = 0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
    endtask

    task automatic do_op(input logic [3:0] op, input logic [3:0] tag,
                         output logic [3:0] cnt, output logic [3:0] rtag,
                         output logic [3:0] rop, output bit ok);
        int t;
        ok = 1'b1;
        req_valid_i = 1'b1; req_opcode_i = op; req_tag_i = tag;
        t = 0;
        while (!req_ready_o && t < 50) begin step(); t++; end
        step();
        req_valid_i = 1'b0;
        t = 0;
        while (!cntr_start_o && t < 50) begin step(); t++; end
        if (!cntr_start_o) ok = 1'b0;
        cnt = cntr_count_o;
        step();
        cntr_done_i = 1'b1;
        step();
        cntr_done_i = 1'b0;
        t = 0;
        while (!rsp_valid_o && t < 50) begin step(); t++; end
        if (!rsp_valid_o) ok = 1'b0;
        rtag = rsp_tag_o;
        rop  = rsp_opcode_o;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready_o, cntr_start_o, cntr_count_o, rsp_valid_o, busy_o} !== 8'b1_0_0000_0_0)
            $display("FAIL reset_outputs: got ready=%0b start=%0b count=%0d rsp_valid=%0b busy=%0b, required 1/0/0/0/0",
                     req_ready_o, cntr_start_o, cntr_count_o, rsp_valid_o, busy_o);
        else n_pass++;
        n_checks++;
        if ({rsp_tag_o, rsp_opcode_o} !== 8'h00)
            $display("FAIL reset_rsp_fields: got tag=%0d op=%0d, required 0/0", rsp_tag_o, rsp_opcode_o);
        else n_pass++;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_op();
        req_valid_i = 1'b1; req_opcode_i = 4'd3; req_tag_i = 4'd5;
        step();
        req_valid_i = 1'b0;
        n_checks++;
        if (cntr_start_o !== 1'b0 || busy_o !== 1'b1)
            $display("FAIL single_accept: got start=%0b busy=%0b, required 0/1", cntr_start_o, busy_o);
        else n_pass++;
        step();
        n_checks++;
        if (cntr_start_o !== 1'b1 || cntr_count_o !== 4'd1)
            $display("FAIL single_issue: got start=%0b count=%0d, required 1/1", cntr_start_o, cntr_count_o);
        else n_pass++;
        step();
        n_checks++;
        if (cntr_start_o !== 1'b0 || cntr_count_o !== 4'd0 || rsp_valid_o !== 1'b0)
            $display("FAIL single_wait: got start=%0b count=%0d rsp_valid=%0b, required 0/0/0",
                     cntr_start_o, cntr_count_o, rsp_valid_o);
        else n_pass++;
        cntr_done_i = 1'b1;
        step();
        cntr_done_i = 1'b0;
        n_checks++;
        if (rsp_valid_o !== 1'b1 || rsp_tag_o !== 4'd5 || rsp_opcode_o !== 4'd3)
            $display("FAIL single_rsp: got valid=%0b tag=%0d op=%0d, required 1/5/3", rsp_valid_o, rsp_tag_o, rsp_opcode_o);
        else n_pass++;
        step();
        n_checks++;
        if (rsp_valid_o !== 1'b1 || rsp_tag_o !== 4'd5)
            $display("FAIL single_rsp_hold: got valid=%0b tag=%0d, required 1/5", rsp_valid_o, rsp_tag_o);
        else n_pass++;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        n_checks++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || rsp_tag_o !== 4'd5 || rsp_opcode_o !== 4'd3)
            $display("FAIL single_done: got valid=%0b busy=%0b tag=%0d op=%0d, required 0/0/5/3",
                     rsp_valid_o, busy_o, rsp_tag_o, rsp_opcode_o);
        else n_pass++;
    endtask

    task automatic test_table();
        logic [3:0] cnt, rtag, rop;
        bit ok;
        logic [3:0] ops   [3] = '{4'd2, 4'd2, 4'd15};
        logic [3:0] dels  [3] = '{4'd9, 4'd0, 4'd15};
        logic [3:0] exps  [3] = '{4'd9, 4'd1, 4'd15};
        for (int k = 0; k < 3; k++) begin
            cfg_we_i = 1'b1; cfg_opcode_i = ops[k]; cfg_delay_i = dels[k];
            step();
            cfg_we_i = 1'b0;
            do_op(ops[k], k[3:0], cnt, rtag, rop, ok);
            n_checks++;
            if (!ok || cnt !== exps[k] || rtag !== k[3:0] || rop !== ops[k])
                $display("FAIL table_%0d: got ok=%0b count=%0d tag=%0d op=%0d, required 1/%0d/%0d/%0d",
                         k, ok, cnt, rtag, rop, exps[k], k, ops[k]);
            else n_pass++;
        end
    endtask

    task automatic test_fifo_full();
        logic [5:0] acc;
        logic [3:0] sent_ops [6];
        logic [3:0] got_tags [$];
        logic [3:0] got_ops  [$];
        rsp_ready_i = 1'b0;
        cntr_done_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid_i  = 1'b1;
            req_tag_i    = i[3:0];
            sent_ops[i]  = 4'($urandom_range(0, 15));
            req_opcode_i = sent_ops[i];
            acc[i]       = req_ready_o;
            step();
        end
        req_valid_i = 1'b0;
        n_checks++;
        if (acc !== 6'b01_1111 || req_ready_o !== 1'b0 || busy_o !== 1'b1)
            $display("FAIL fifo_full_accept: got accepted=%b ready=%0b busy=%0b, required 011111/0/1",
                     acc, req_ready_o, busy_o);
        else n_pass++;
        cntr_done_i = 1'b1;
        step();
        cntr_done_i = 1'b0;
        auto_done   = 1'b1;
        rsp_ready_i = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (rsp_valid_o && rsp_ready_i) begin
                got_tags.push_back(rsp_tag_o);
                got_ops.push_back(rsp_opcode_o);
            end
            step();
            if (got_tags.size() == 5) break;
        end
        rsp_ready_i = 1'b0;
        auto_done   = 1'b0;
        cntr_done_i = 1'b0;
        n_checks++;
        if (got_tags.size() != 5)
            $display("FAIL fifo_rsp_count: got %0d responses, required 5", got_tags.size());
        else n_pass++;
        for (int k = 0; k < got_tags.size(); k++) begin
            n_checks++;
            if (got_tags[k] !== k[3:0] || got_ops[k] !== sent_ops[k])
                $display("FAIL fifo_rsp_order_%0d: got tag=%0d op=%0d, required %0d/%0d",
                         k, got_tags[k], got_ops[k], k, sent_ops[k]);
            else n_pass++;
        end
        n_checks++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0)
            $display("FAIL fifo_drained: got ready=%0b busy=%0b, required 1/0", req_ready_o, busy_o);
        else n_pass++;
    endtask

    task automatic test_done_interlock();
        cntr_done_i = 1'b1;
        req_valid_i = 1'b1; req_opcode_i = 4'd3; req_tag_i = 4'd7;
        step();
        req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cntr_start_o !== 1'b0)
                $display("FAIL interlock_hold_%0d: got start=%0b, required 0", i, cntr_start_o);
            else n_pass++;
            step();
        end
        cntr_done_i = 1'b0;
        step();
        n_checks++;
        if (cntr_start_o !== 1'b1)
            $display("FAIL interlock_release: got start=%0b, required 1", cntr_start_o);
        else n_pass++;
        step();
        cntr_done_i = 1'b1;
        step();
        n_checks++;
        if (rsp_valid_o !== 1'b1 || rsp_tag_o !== 4'd7)
            $display("FAIL interlock_rsp: got valid=%0b tag=%0d, required 1/7", rsp_valid_o, rsp_tag_o);
        else n_pass++;
        step();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        step();
        cntr_done_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rsp_valid_o !== 1'b0 || cntr_start_o !== 1'b0 || busy_o !== 1'b0)
                $display("FAIL interlock_no_extra_%0d: got valid=%0b start=%0b busy=%0b, required 0/0/0",
                         i, rsp_valid_o, cntr_start_o, busy_o);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_reset_midop();
        logic [3:0] cnt, rtag, rop;
        bit ok;
        cfg_we_i = 1'b1; cfg_opcode_i = 4'd6; cfg_delay_i = 4'd12;
        step();
        cfg_we_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            req_valid_i = 1'b1; req_opcode_i = 4'd6; req_tag_i = i[3:0];
            step();
            if (i == 2) begin
                n_checks++;
                if (cntr_start_o !== 1'b1 || cntr_count_o !== 4'd12)
                    $display("FAIL midop_issue: got start=%0b count=%0d, required 1/12", cntr_start_o, cntr_count_o);
                else n_pass++;
            end
        end
        req_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready_o, cntr_start_o, cntr_count_o, rsp_valid_o, busy_o, rsp_tag_o, rsp_opcode_o} !== 16'h8000)
            $display("FAIL midop_reset_outputs: got ready=%0b start=%0b count=%0d valid=%0b busy=%0b tag=%0d op=%0d, required 1/0/0/0/0/0/0",
                     req_ready_o, cntr_start_o, cntr_count_o, rsp_valid_o, busy_o, rsp_tag_o, rsp_opcode_o);
        else n_pass++;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        cntr_done_i = 1'b1;
        step();
        cntr_done_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rsp_valid_o !== 1'b0 || cntr_start_o !== 1'b0 || busy_o !== 1'b0)
                $display("FAIL midop_dropped_%0d: got valid=%0b start=%0b busy=%0b, required 0/0/0",
                         i, rsp_valid_o, cntr_start_o, busy_o);
            else n_pass++;
            step();
        end
        do_op(4'd6, 4'd9, cnt, rtag, rop, ok);
        n_checks++;
        if (!ok || cnt !== 4'd1 || rtag !== 4'd9)
            $display("FAIL midop_table_reset: got ok=%0b count=%0d tag=%0d, required 1/1/9", ok, cnt, rtag);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [3:0] tbl [16];
        logic [7:0] infl;
        bit         active;
        bit         drain;
        logic       push, hs;
        int         pushed, rsps;
        infl = '0; active = 1'b0; pushed = 0; rsps = 0;
        do_reset();
        for (int i = 0; i < 16; i++) tbl[i] = 4'd1;
        auto_done = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drain = (cyc >= 2000);
            if (drain && q.size() == 0 && !active) break;
            req_valid_i  = !drain && ($urandom_range(0, 2) != 0);
            req_opcode_i = 4'($urandom_range(0, 15));
            req_tag_i    = 4'($urandom_range(0, 15));
            cfg_we_i     = !drain && ($urandom_range(0, 9) == 0);
            cfg_opcode_i = 4'($urandom_range(0, 15));
            cfg_delay_i  = 4'($urandom_range(0, 5));
            rsp_ready_i  = drain || ($urandom_range(0, 2) != 0);
            push = req_valid_i && req_ready_o;
            hs   = rsp_valid_o && rsp_ready_i;

            n_checks++;
            if (req_ready_o !== (q.size() < DEPTH))
                $display("FAIL rand_ready@%0d: got %0b, required %0b", cyc, req_ready_o, q.size() < DEPTH);
            else n_pass++;
            n_checks++;
            if (busy_o !== (q.size() > 0 || active))
                $display("FAIL rand_busy@%0d: got %0b, required %0b", cyc, busy_o, q.size() > 0 || active);
            else n_pass++;
            if (cntr_start_o) begin
                n_checks++;
                if (q.size() == 0 || active)
                    $display("FAIL rand_start@%0d: got start with queued=%0d active=%0b, required queued>0 active=0",
                             cyc, q.size(), active);
                else if (cntr_count_o !== tbl[q[0][7:4]])
                    $display("FAIL rand_count@%0d: got %0d, required %0d", cyc, cntr_count_o, tbl[q[0][7:4]]);
                else n_pass++;
            end else begin
                n_checks++;
                if (cntr_count_o !== 4'd0)
                    $display("FAIL rand_count_idle@%0d: got %0d, required 0", cyc, cntr_count_o);
                else n_pass++;
            end
            if (rsp_valid_o) begin
                n_checks++;
                if (!active || {rsp_opcode_o, rsp_tag_o} !== infl)
                    $display("FAIL rand_rsp@%0d: got op=%0d tag=%0d active=%0b, required op=%0d tag=%0d active=1",
                             cyc, rsp_opcode_o, rsp_tag_o, active, infl[7:4], infl[3:0]);
                else n_pass++;
            end

            if (cntr_start_o && q.size() > 0) begin
                infl   = q.pop_front();
                active = 1'b1;
            end
            if (push) begin
                q.push_back({req_opcode_i, req_tag_i});
                pushed++;
            end
            if (cfg_we_i) tbl[cfg_opcode_i] = (cfg_delay_i == 4'd0) ? 4'd1 : cfg_delay_i;
            if (hs) begin
                active = 1'b0;
                rsps++;
            end
            step();
        end
        idle_inputs();
        auto_done = 1'b0;
        n_checks++;
        if (q.size() != 0 || active || rsps != pushed || pushed == 0)
            $display("FAIL rand_drain: got queued=%0d active=%0b responses=%0d accepted=%0d, required 0/0/equal/nonzero",
                     q.size(), active, rsps, pushed);
        else n_pass++;
    endtask

`ifdef VPU_ISSUE_PERF_EN
    task automatic test_perf();
        int  nonidle, rsps, sent;
        bit  act;
        nonidle = 0; rsps = 0; sent = 0; act = 1'b0;
        do_reset();
        cfg_we_i = 1'b1; cfg_opcode_i = 4'd4; cfg_delay_i = 4'd2;
        step();
        cfg_we_i = 1'b0;
        auto_done   = 1'b1;
        rsp_ready_i = 1'b1;
        for (int c = 0; c < 200; c++) begin
            req_valid_i  = (sent < 3);
            req_opcode_i = 4'd4;
            req_tag_i    = sent[3:0];
            if (req_valid_i && req_ready_o) sent++;
            if (cntr_start_o || act) nonidle++;
            if (cntr_start_o) act = 1'b1;
            if (rsp_valid_o && rsp_ready_i) begin act = 1'b0; rsps++; end
            step();
            if (rsps == 3) break;
        end
        idle_inputs();
        auto_done = 1'b0;
        step();
        n_checks++;
        if (perf_ops_o !== 16'd3)
            $display("FAIL perf_ops: got %0d, required 3", perf_ops_o);
        else n_pass++;
        n_checks++;
        if (perf_busy_cycles_o !== 32'(nonidle) || nonidle == 0)
            $display("FAIL perf_busy: got %0d, required %0d", perf_busy_cycles_o, nonidle);
        else n_pass++;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_op();
        test_table();
        test_fifo_full();
        test_done_interlock();
        do_reset();
        test_reset_midop();
        test_random();
`ifdef VPU_ISSUE_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
